rv_datapath_param: RTL and testbench

Parametrised multicycle RISC-V datapath, successor to the fixed 32-bit multicycle datapath. Generalised in register width (RV32/RV64) and register count (RV32E/RV32I), with a memory-ready stall, sub-word load extraction, store byte-lane alignment and byte enables. Sits between the multicycle control FSM and the unified instruction/data memory port; the control FSM drives all select/enable inputs and observes flags and instruction fields.

---
 rtl/rv_datapath_param.sv | 242 ++++++++++++++++++++++++
 tb/tb_rv_datapath_param.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_datapath_param.sv
// rv_datapath_param: parametrised multicycle RISC-V datapath (RV32/RV64, E/I).
// Holds PC, OldPC, IR, Data, A, WD, ALUOut and the register file. The
// multicycle control FSM drives the selects and enables.
// Ports:
//   clk, reset (async, active high).
//   RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc, ALUControl: control from the FSM.
//   Mem_RdData, Mem_Ready: memory read data and access-complete.
//   PC, Zero/Negative/Carry/Overflow, op/func3/func7b5: observed by the FSM.
//   Mem_Addr, Mem_WrData, Mem_ByteEn: memory request. Result, Stall.
module rv_datapath_param #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              IRWrite,
    input  logic              PCWrite,
    input  logic              MemWrite,
    input  logic              AdrSrc,
    input  logic [1:0]        ResultSrc,
    input  logic [1:0]        ALUSrcA,
    input  logic [1:0]        ALUSrcB,
    input  logic [2:0]        ImmSrc,
    input  logic [3:0]        ALUControl,
    input  logic [XLEN-1:0]   Mem_RdData,
    input  logic              Mem_Ready,
    output logic [XLEN-1:0]   PC,
    output logic              Zero,
    output logic              Negative,
    output logic              Carry,
    output logic              Overflow,
    output logic [6:0]        op,
    output logic [2:0]        func3,
    output logic              func7b5,
    output logic [XLEN-1:0]   Mem_Addr,
    output logic [XLEN-1:0]   Mem_WrData,
    output logic [XLEN/8-1:0] Mem_ByteEn,
    output logic [XLEN-1:0]   Result,
    output logic              Stall
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int SHW  = $clog2(XLEN);
    localparam int RIW  = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d;
    logic [XLEN-1:0] data_q, data_d, a_q, a_d;
    logic [XLEN-1:0] wd_q, wd_d, aluout_q, aluout_d;
    logic [31:0]     ir_q, ir_d, ir_word;
    logic [XLEN-1:0] rf_q [NREGS];

    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, srca, srcb, imm_ext, alu_res, load_ext;
    logic [31:0]     imm32, lsh;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;
    logic [SHW-1:0]  shamt;
    logic [7:0]      lane8;
    logic            sub_op, rf_we;

    assign Stall   = ~Mem_Ready;
    assign PC      = pc_q;
    assign op      = ir_q[6:0];
    assign func3   = ir_q[14:12];
    assign func7b5 = ir_q[30];
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign rd      = ir_q[11:7];

    // On RV64 the fetched word is the 32-bit half addressed by PC[2].
    if (XLEN == 64) begin : g_ir64
        assign ir_word = pc_q[2] ? Mem_RdData[63:32] : Mem_RdData[31:0];
    end else begin : g_ir32
        assign ir_word = Mem_RdData[31:0];
    end

    // x0 and indexes beyond the implemented file read as zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0 && {1'b0, rs1} < NREGS_L) rd1 = rf_q[rs1[RIW-1:0]];
        if (rs2 != 5'd0 && {1'b0, rs2} < NREGS_L) rd2 = rf_q[rs2[RIW-1:0]];
    end

    assign rf_we = RegWrite & Mem_Ready & (rd != 5'd0) & ({1'b0, rd} < NREGS_L);

    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rd[RIW-1:0]] <= Result;
    end

    always_comb begin
        case (ImmSrc)
            3'b000:  imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            3'b001:  imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            3'b010:  imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                              ir_q[30:25], ir_q[11:8], 1'b0};
            3'b011:  imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                              ir_q[20], ir_q[30:21], 1'b0};
            3'b100:  imm32 = {ir_q[31:12], 12'h000};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    always_comb begin
        case (ALUSrcA)
            2'b00:   srca = pc_q;
            2'b01:   srca = oldpc_q;
            2'b10:   srca = a_q;
            default: srca = '0;
        endcase
        case (ALUSrcB)
            2'b00:   srcb = wd_q;
            2'b01:   srcb = imm_ext;
            2'b10:   srcb = XLEN'(4);
            default: srcb = '0;
        endcase
    end

    // Subtract is a + ~b + 1, so carry-out is the no-borrow flag and the
    // add overflow rule applies unchanged against the inverted operand.
    always_comb begin
        sub_op   = (ALUControl == 4'b0001);
        b_eff    = sub_op ? ~srcb : srcb;
        sum      = {1'b0, srca} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_op};
        shamt    = srcb[SHW-1:0];
        alu_res  = '0;
        Carry    = 1'b0;
        Overflow = 1'b0;
        case (ALUControl)
            4'b0000, 4'b0001: begin
                alu_res  = sum[XLEN-1:0];
                Carry    = sum[XLEN];
                Overflow = (srca[XLEN-1] == b_eff[XLEN-1]) &&
                           (sum[XLEN-1] != srca[XLEN-1]);
            end
            4'b0010: alu_res = srca & srcb;
            4'b0011: alu_res = srca | srcb;
            4'b0100: alu_res = srca ^ srcb;
            4'b0101: alu_res = XLEN'($signed(srca) < $signed(srcb));
            4'b0110: alu_res = XLEN'(srca < srcb);
            4'b0111: alu_res = srca << shamt;
            4'b1000: alu_res = srca >> shamt;
            4'b1001: alu_res = $signed(srca) >>> shamt;
            default: alu_res = '0;
        endcase
        Zero     = (alu_res == '0);
        Negative = alu_res[XLEN-1];
    end

    // Sub-word loads take lanes from the ALUOut offset, aligned or not.
    always_comb begin
        lsh = 32'(data_q >> {aluout_q[OFFW-1:0], 3'b000});
        case (func3)
            3'b000:  load_ext = XLEN'($signed(lsh[7:0]));
            3'b001:  load_ext = XLEN'($signed(lsh[15:0]));
            3'b010:  load_ext = XLEN'($signed(lsh));
            3'b100:  load_ext = XLEN'(lsh[7:0]);
            3'b101:  load_ext = XLEN'(lsh[15:0]);
            3'b110:  load_ext = XLEN'(lsh);
            default: load_ext = data_q;
        endcase
    end

    always_comb begin
        case (ResultSrc)
            2'b00:   Result = aluout_q;
            2'b01:   Result = load_ext;
            2'b10:   Result = alu_res;
            default: Result = imm_ext;
        endcase
    end

    assign Mem_Addr = AdrSrc ? Result : pc_q;

    always_comb begin
        case (func3[1:0])
            2'b00: begin
                Mem_WrData = {NB{wd_q[7:0]}};
                lane8      = 8'h01;
            end
            2'b01: begin
                Mem_WrData = {(NB/2){wd_q[15:0]}};
                lane8      = 8'h03;
            end
            2'b10: begin
                Mem_WrData = {(XLEN/32){wd_q[31:0]}};
                lane8      = 8'h0F;
            end
            default: begin
                Mem_WrData = wd_q;
                lane8      = 8'hFF;
            end
        endcase
        Mem_ByteEn = MemWrite ? (NB'(lane8) << Mem_Addr[OFFW-1:0]) : '0;
    end

    always_comb begin
        pc_d     = pc_q;
        oldpc_d  = oldpc_q;
        ir_d     = ir_q;
        data_d   = data_q;
        a_d      = a_q;
        wd_d     = wd_q;
        aluout_d = aluout_q;
        if (Mem_Ready) begin
            data_d   = Mem_RdData;
            a_d      = rd1;
            wd_d     = rd2;
            aluout_d = alu_res;
            if (PCWrite) pc_d = Result;
            if (IRWrite) begin
                oldpc_d = pc_q;
                ir_d    = ir_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= '0;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            ir_q     <= ir_d;
            data_q   <= data_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            aluout_q <= aluout_d;
        end
    end
endmodule

// File: tb/tb_rv_datapath_param.sv
// tb_rv_datapath_param: drives an RV32I (RESET_PC=0x100) and an RV64E
// instance of rv_datapath_param through fetch, stall, ALU, load and store.
module tb_rv_datapath_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        Mem_Ready;
    logic [31:0] rd32;
    logic [63:0] rd64;

    logic [31:0] pc32, addr32, wdat32, res32;
    logic        z32, n32, c32, v32, f7_32, st32;
    logic [6:0]  op32;
    logic [2:0]  f3_32;
    logic [3:0]  be32;

    logic [63:0] pc64, addr64, wdat64, res64;
    logic        z64, n64, c64, v64, f7_64, st64;
    logic [6:0]  op64;
    logic [2:0]  f3_64;
    logic [7:0]  be64;

    rv_datapath_param #(.XLEN(32), .NREGS(32), .RESET_PC(32'h100)) u32 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Mem_RdData(rd32),
        .Mem_Ready(Mem_Ready), .PC(pc32), .Zero(z32), .Negative(n32),
        .Carry(c32), .Overflow(v32), .op(op32), .func3(f3_32),
        .func7b5(f7_32), .Mem_Addr(addr32), .Mem_WrData(wdat32),
        .Mem_ByteEn(be32), .Result(res32), .Stall(st32)
    );

    rv_datapath_param #(.XLEN(64), .NREGS(16)) u64 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Mem_RdData(rd64),
        .Mem_Ready(Mem_Ready), .PC(pc64), .Zero(z64), .Negative(n64),
        .Carry(c64), .Overflow(v64), .op(op64), .func3(f3_64),
        .func7b5(f7_64), .Mem_Addr(addr64), .Mem_WrData(wdat64),
        .Mem_ByteEn(be64), .Result(res64), .Stall(st64)
    );

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a, b, res;
        logic [3:0]  fl;
    } alu_vec_t;
    typedef struct {
        logic [11:0] off;
        logic [2:0]  f3;
        logic [31:0] data, res;
    } ld_vec_t;
    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  off;
        logic [31:0] wdat;
        logic [3:0]  be;
    } st_vec_t;

    alu_vec_t av[14];
    ld_vec_t  lv[9];
    st_vec_t  sv[5];

    task automatic expect_val(input string n, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [63:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %h", act);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (act !== e.val) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, act, e.val);
        end
    endtask

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        expect_val(n, exp);
        compare(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b10;
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b11;
        ImmSrc     = 3'b000;
        ALUControl = 4'b0000;
        Mem_Ready  = 1'b1;
    endtask

    task automatic set_ir(input logic [31:0] ins);
        idle();
        rd32    = ins;
        rd64    = {ins, ins};
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
    endtask

    // Load-type IR (func3=011) with ALUOut=0, then route Data to rd.
    task automatic write_reg(input logic [4:0] r, input logic [63:0] v);
        set_ir({12'h000, 5'd0, 3'b011, r, 7'h03});
        rd32 = v[31:0];
        rd64 = v;
        tick();
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        tick();
        RegWrite  = 1'b0;
        ResultSrc = 2'b10;
    endtask

    task automatic read_ab(input logic [4:0] r1, input logic [4:0] r2);
        set_ir({7'h00, r2, r1, 3'b000, 5'd0, 7'h33});
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        av[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
        av[1]  = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1010};
        av[2]  = '{4'b1001, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0100};
        av[3]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
        av[4]  = '{4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0100};
        av[5]  = '{4'b0010, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 4'b0000};
        av[6]  = '{4'b0011, 32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b0100};
        av[7]  = '{4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000};
        av[8]  = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
        av[9]  = '{4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000};
        av[10] = '{4'b0111, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000};
        av[11] = '{4'b1000, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000};
        av[12] = '{4'b1111, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000};
        av[13] = '{4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};

        lv[0] = '{12'd1, 3'b000, 32'h8001FF7F, 32'hFFFFFFFF};
        lv[1] = '{12'd1, 3'b100, 32'h8001FF7F, 32'h000000FF};
        lv[2] = '{12'd2, 3'b101, 32'h8001FF7F, 32'h00008001};
        lv[3] = '{12'd0, 3'b001, 32'h8001FF7F, 32'hFFFFFF7F};
        lv[4] = '{12'd0, 3'b010, 32'h8001FF7F, 32'h8001FF7F};
        lv[5] = '{12'd3, 3'b000, 32'h8001FF7F, 32'hFFFFFF80};
        lv[6] = '{12'd3, 3'b100, 32'h8001FF7F, 32'h00000080};
        lv[7] = '{12'd0, 3'b111, 32'h8001FF7F, 32'h8001FF7F};
        lv[8] = '{12'd2, 3'b001, 32'h8001FF7F, 32'hFFFF8001};

        sv[0] = '{3'b001, 5'd2, 32'h56785678, 4'b1100};
        sv[1] = '{3'b000, 5'd3, 32'h78787878, 4'b1000};
        sv[2] = '{3'b010, 5'd0, 32'h12345678, 4'b1111};
        sv[3] = '{3'b000, 5'd1, 32'h78787878, 4'b0010};
        sv[4] = '{3'b001, 5'd0, 32'h56785678, 4'b0011};

        idle();
        rd32  = '0;
        rd64  = '0;
        reset = 1'b1;
        #12 reset = 1'b0;
        chk("rst_pc", 64'(pc32), 64'h100);
        chk("rst_op", 64'(op32), 64'h0);

        rd32       = 32'hFFFFFFFF;
        rd64       = '1;
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        tick();
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        chk("pre_pc", 64'(pc32), 64'h104);
        chk("pre_op", 64'(op32), 64'h7F);

        Mem_Ready = 1'b0;
        tick();
        #3 reset = 1'b1;
        #1;
        chk("rst_stall_pc", 64'(pc32), 64'h100);
        chk("rst_stall_op", 64'(op32), 64'h0);
        chk("rst_stall_f3", 64'(f3_32), 64'h0);
        chk("rst_stall_f7", 64'(f7_32), 64'h0);
        chk("rst_stall_be", 64'(be32), 64'h0);
        chk("rst_stall_flag", 64'(st32), 64'h1);
        chk("rst_addr", 64'(addr32), 64'h100);
        #2 reset = 1'b0;

        Mem_Ready = 1'b1;
        rd32      = 32'h00500093;
        rd64      = {2{32'h00500093}};
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        #1;
        chk("fetch_addr", 64'(addr32), 64'h100);
        tick();
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        chk("fetch_op", 64'(op32), 64'h13);
        chk("fetch_f3", 64'(f3_32), 64'h0);
        chk("fetch_pc", 64'(pc32), 64'h104);
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b11;
        #1;
        chk("fetch_oldpc", 64'(res32), 64'h100);

        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        rd32      = 32'h40000033;
        rd64      = {2{32'h40000033}};
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        Mem_Ready = 1'b0;
        #1;
        chk("stall_out", 64'(st32), 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_pc", i), 64'(pc32), 64'h104);
            chk($sformatf("stall%0d_op", i), 64'(op32), 64'h13);
            chk($sformatf("stall%0d_f7", i), 64'(f7_32), 64'h0);
        end
        Mem_Ready = 1'b1;
        tick();
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        chk("release_pc", 64'(pc32), 64'h108);
        chk("release_op", 64'(op32), 64'h33);
        chk("release_f7", 64'(f7_32), 64'h1);
        chk("release_stall", 64'(st32), 64'h0);
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b11;
        #1;
        chk("release_oldpc", 64'(res32), 64'h104);

        for (int i = 0; i < 14; i++) begin
            write_reg(5'd1, 64'(av[i].a));
            write_reg(5'd2, 64'(av[i].b));
            read_ab(5'd1, 5'd2);
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b00;
            ALUControl = av[i].ctl;
            ResultSrc  = 2'b10;
            expect_val($sformatf("alu%0d_res", i), 64'(av[i].res));
            expect_val($sformatf("alu%0d_zncv", i), 64'(av[i].fl));
            #1;
            compare(64'(res32));
            compare(64'({z32, n32, c32, v32}));
        end

        for (int i = 0; i < 9; i++) begin
            set_ir({lv[i].off, 5'd0, lv[i].f3, 5'd0, 7'h03});
            rd32    = lv[i].data;
            rd64    = 64'(lv[i].data);
            ALUSrcB = 2'b01;
            tick();
            ResultSrc = 2'b01;
            expect_val($sformatf("load%0d", i), 64'(lv[i].res));
            #1;
            compare(64'(res32));
        end

        write_reg(5'd2, 64'h12345678);
        for (int i = 0; i < 5; i++) begin
            set_ir({7'h00, 5'd2, 5'd0, sv[i].f3, sv[i].off, 7'h23});
            tick();
            ImmSrc    = 3'b001;
            ResultSrc = 2'b11;
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
            expect_val($sformatf("st%0d_addr", i), 64'(sv[i].off));
            expect_val($sformatf("st%0d_wdata", i), 64'(sv[i].wdat));
            expect_val($sformatf("st%0d_be", i), 64'(sv[i].be));
            #1;
            compare(64'(addr32));
            compare(64'(wdat32));
            compare(64'(be32));
            MemWrite = 1'b0;
            expect_val($sformatf("st%0d_be_off", i), 64'h0);
            #1;
            compare(64'(be32));
        end

        write_reg(5'd4, 64'h77);
        write_reg(5'd20, 64'h1234);
        write_reg(5'd5, 64'hDEADBEEF_CAFEF00D);
        write_reg(5'd0, 64'h55);
        read_ab(5'd20, 5'd5);
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b11;
        #1;
        chk("rv64e_x20", res64, 64'h0);
        chk("rv32i_x20", 64'(res32), 64'h1234);
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b00;
        #1;
        chk("rv64e_x5", res64, 64'hDEADBEEF_CAFEF00D);
        read_ab(5'd0, 5'd4);
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b11;
        #1;
        chk("rv64e_x0", res64, 64'h0);
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b00;
        #1;
        chk("rv64e_x4", res64, 64'h77);

        set_ir({12'd0, 5'd0, 3'b011, 5'd0, 7'h03});
        rd64    = 64'h88776655_44332211;
        ALUSrcB = 2'b01;
        tick();
        ResultSrc = 2'b01;
        #1;
        chk("rv64_ld", res64, 64'h88776655_44332211);

        set_ir({12'd0, 5'd0, 3'b010, 5'd0, 7'h03});
        rd64    = 64'h00000000_80000000;
        ALUSrcB = 2'b01;
        tick();
        ResultSrc = 2'b01;
        #1;
        chk("rv64_lw", res64, 64'hFFFFFFFF_80000000);

        set_ir({12'd4, 5'd0, 3'b110, 5'd0, 7'h03});
        rd64    = 64'h90000001_00000000;
        ALUSrcB = 2'b01;
        tick();
        ResultSrc = 2'b01;
        #1;
        chk("rv64_lwu", res64, 64'h00000000_90000001);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
